// File: rtl/attn_pass_scheduler_pkg.sv
// Shared types and constants for the attention pass scheduler:
// operand-source encoding, FSM states and the fixed memory layout constants.
package attn_pkg;

  typedef enum logic [1:0] {
    SRC_INPUT   = 2'd0,
    SRC_WEIGHT  = 2'd1,
    SRC_RESULT  = 2'd2,
    SRC_SCRATCH = 2'd3
  } src_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_HDR = 3'd1,
    ST_LD_HDR = 3'd2,
    ST_CALC   = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam int PASS_CNT  = 5;
  localparam int PASS_W    = 3;
  localparam int HDR_ADDR  = 0;
  // Matrix data in the input and weight SRAMs starts right after the header word.
  localparam int DATA_BASE = 1;

endpackage

// File: rtl/attn_pass_scheduler_if.sv
// Descriptor channel between the pass scheduler (master) and the MAC engine (slave),
// including the engine's one-cycle completion pulse.
interface attn_pass_scheduler_if #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 16
);
  import attn_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  src_e              cmd_a_src;
  src_e              cmd_b_src;
  logic [ADDR_W-1:0] cmd_a_base;
  logic [ADDR_W-1:0] cmd_b_base;
  logic [ADDR_W-1:0] cmd_dst_base;
  logic              cmd_b_trans;
  logic [DIM_W-1:0]  cmd_m;
  logic [DIM_W-1:0]  cmd_k;
  logic [DIM_W-1:0]  cmd_n;
  logic              cmd_scr_copy;
  logic              eng_done;

  modport master (
    output cmd_valid, cmd_a_src, cmd_b_src, cmd_a_base, cmd_b_base, cmd_dst_base,
           cmd_b_trans, cmd_m, cmd_k, cmd_n, cmd_scr_copy,
    input  cmd_ready, eng_done
  );

  modport slave (
    input  cmd_valid, cmd_a_src, cmd_b_src, cmd_a_base, cmd_b_base, cmd_dst_base,
           cmd_b_trans, cmd_m, cmd_k, cmd_n, cmd_scr_copy,
    output cmd_ready, eng_done
  );

endinterface

// File: rtl/attn_pass_scheduler_desc_gen.sv
// Combinational pass-index to descriptor mapping for the Q, K, V, S and Z passes.
// Address sums are formed at full product width and truncated to ADDR_W.
module attn_desc_gen
  import attn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 16,
  parameter int PROD_W = 2 * DIM_W
) (
  input  logic [PASS_W-1:0] pass_idx_i,
  input  logic [DIM_W-1:0]  ri_i,
  input  logic [DIM_W-1:0]  ci_i,
  input  logic [DIM_W-1:0]  cw_i,
  input  logic [PROD_W-1:0] wd_i,
  input  logic [PROD_W-1:0] p_i,
  input  logic [PROD_W-1:0] ss_i,
  output src_e              a_src_o,
  output src_e              b_src_o,
  output logic [ADDR_W-1:0] a_base_o,
  output logic [ADDR_W-1:0] b_base_o,
  output logic [ADDR_W-1:0] dst_base_o,
  output logic              b_trans_o,
  output logic [DIM_W-1:0]  m_o,
  output logic [DIM_W-1:0]  k_o,
  output logic [DIM_W-1:0]  n_o,
  output logic              scr_copy_o
);

  logic [PROD_W-1:0] base;
  logic [PROD_W-1:0] p3;
  logic [PROD_W-1:0] a_full;
  logic [PROD_W-1:0] b_full;
  logic [PROD_W-1:0] d_full;

  assign base = PROD_W'(DATA_BASE);
  assign p3   = p_i + (p_i << 1);

  always_comb begin
    a_src_o    = SRC_INPUT;
    b_src_o    = SRC_WEIGHT;
    a_full     = base;
    b_full     = base;
    d_full     = '0;
    b_trans_o  = 1'b0;
    m_o        = ri_i;
    k_o        = ci_i;
    n_o        = cw_i;
    scr_copy_o = 1'b0;
    case (pass_idx_i)
      3'd0: ; // Q uses the projection defaults
      3'd1: begin
        // K is also copied to scratch so S can read it transposed
        b_full     = base + wd_i;
        d_full     = p_i;
        scr_copy_o = 1'b1;
      end
      3'd2: begin
        b_full = base + (wd_i << 1);
        d_full = p_i << 1;
      end
      3'd3: begin
        a_src_o   = SRC_RESULT;
        b_src_o   = SRC_SCRATCH;
        a_full    = '0;
        b_full    = '0;
        b_trans_o = 1'b1;
        k_o       = cw_i;
        n_o       = ri_i;
        d_full    = p3;
      end
      3'd4: begin
        a_src_o = SRC_RESULT;
        b_src_o = SRC_RESULT;
        a_full  = p3;
        b_full  = p_i << 1;
        k_o     = ri_i;
        d_full  = p3 + ss_i;
      end
      default: begin
        a_src_o = SRC_INPUT;
        b_src_o = SRC_INPUT;
        a_full  = '0;
        b_full  = '0;
        m_o     = '0;
        k_o     = '0;
        n_o     = '0;
      end
    endcase
  end

  assign a_base_o   = a_full[ADDR_W-1:0];
  assign b_base_o   = b_full[ADDR_W-1:0];
  assign dst_base_o = d_full[ADDR_W-1:0];

endmodule

// File: rtl/attn_pass_scheduler.sv
// Job-level sequencer for one self-attention job: reads the dimension headers,
// validates them, then issues the five MAC passes one at a time.
module attn_pass_scheduler
  import attn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   dut_valid,
  output logic                   dut_ready,
  output logic [ADDR_W-1:0]      hdr_rd_addr,
  output logic                   hdr_own,
  input  logic [DATA_W-1:0]      input_hdr,
  input  logic [DATA_W-1:0]      weight_hdr,
  attn_pass_scheduler_if.master  cmd,
  output logic                   dim_err
);

  localparam int PROD_W = 2 * DIM_W;
  localparam int ROW_LO = DATA_W / 2;

  state_e              state_q, state_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic                dim_err_q, dim_err_d;
  logic                dut_ready_q;
  logic [DIM_W-1:0]    ri_q, ci_q, rw_q, cw_q;
  logic [PROD_W-1:0]   wd_q, p_q, ss_q;
  logic                dims_bad;

  src_e                gen_a_src, gen_b_src;
  logic [ADDR_W-1:0]   gen_a_base, gen_b_base, gen_dst_base;
  logic                gen_b_trans, gen_scr_copy;
  logic [DIM_W-1:0]    gen_m, gen_k, gen_n;

  assign dims_bad = (ci_q != rw_q) || (ri_q == '0) || (ci_q == '0) ||
                    (rw_q == '0) || (cw_q == '0);

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    dim_err_d = dim_err_q;
    case (state_q)
      ST_IDLE:   if (dut_valid) state_d = ST_RD_HDR;
      ST_RD_HDR: state_d = ST_LD_HDR;
      ST_LD_HDR: state_d = ST_CALC;
      ST_CALC: begin
        pass_d    = '0;
        dim_err_d = dims_bad;
        state_d   = dims_bad ? ST_DONE : ST_ISSUE;
      end
      // eng_done is deliberately not looked at here, even alongside an accept
      ST_ISSUE:  if (cmd.cmd_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (cmd.eng_done) begin
          pass_d  = pass_q + PASS_W'(1);
          state_d = (pass_q == PASS_W'(PASS_CNT - 1)) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pass_q      <= '0;
      dim_err_q   <= 1'b0;
      dut_ready_q <= 1'b0;
      ri_q        <= '0;
      ci_q        <= '0;
      rw_q        <= '0;
      cw_q        <= '0;
      wd_q        <= '0;
      p_q         <= '0;
      ss_q        <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      dim_err_q   <= dim_err_d;
      dut_ready_q <= (state_d == ST_IDLE);
      // Header SRAM has one cycle of read latency: data is valid during LD_HDR.
      if (state_q == ST_LD_HDR) begin
        ri_q <= input_hdr[ROW_LO +: DIM_W];
        ci_q <= input_hdr[0 +: DIM_W];
        rw_q <= weight_hdr[ROW_LO +: DIM_W];
        cw_q <= weight_hdr[0 +: DIM_W];
      end
      if (state_q == ST_CALC) begin
        wd_q <= PROD_W'(rw_q) * PROD_W'(cw_q);
        p_q  <= PROD_W'(ri_q) * PROD_W'(cw_q);
        ss_q <= PROD_W'(ri_q) * PROD_W'(ri_q);
      end
    end
  end

  attn_desc_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W),
    .PROD_W (PROD_W)
  ) u_desc_gen (
    .pass_idx_i (pass_q),
    .ri_i       (ri_q),
    .ci_i       (ci_q),
    .cw_i       (cw_q),
    .wd_i       (wd_q),
    .p_i        (p_q),
    .ss_i       (ss_q),
    .a_src_o    (gen_a_src),
    .b_src_o    (gen_b_src),
    .a_base_o   (gen_a_base),
    .b_base_o   (gen_b_base),
    .dst_base_o (gen_dst_base),
    .b_trans_o  (gen_b_trans),
    .m_o        (gen_m),
    .k_o        (gen_k),
    .n_o        (gen_n),
    .scr_copy_o (gen_scr_copy)
  );

  assign dut_ready   = dut_ready_q;
  assign dim_err     = dim_err_q;
  assign hdr_own     = (state_q == ST_RD_HDR) || (state_q == ST_LD_HDR);
  assign hdr_rd_addr = ADDR_W'(HDR_ADDR);

  // Descriptor fields read as zero whenever no descriptor is being offered.
  always_comb begin
    cmd.cmd_valid    = (state_q == ST_ISSUE);
    cmd.cmd_a_src    = SRC_INPUT;
    cmd.cmd_b_src    = SRC_INPUT;
    cmd.cmd_a_base   = '0;
    cmd.cmd_b_base   = '0;
    cmd.cmd_dst_base = '0;
    cmd.cmd_b_trans  = 1'b0;
    cmd.cmd_m        = '0;
    cmd.cmd_k        = '0;
    cmd.cmd_n        = '0;
    cmd.cmd_scr_copy = 1'b0;
    if (state_q == ST_ISSUE) begin
      cmd.cmd_a_src    = gen_a_src;
      cmd.cmd_b_src    = gen_b_src;
      cmd.cmd_a_base   = gen_a_base;
      cmd.cmd_b_base   = gen_b_base;
      cmd.cmd_dst_base = gen_dst_base;
      cmd.cmd_b_trans  = gen_b_trans;
      cmd.cmd_m        = gen_m;
      cmd.cmd_k        = gen_k;
      cmd.cmd_n        = gen_n;
      cmd.cmd_scr_copy = gen_scr_copy;
    end
  end

endmodule

// File: tb/tb_attn_pass_scheduler.sv
// Directed bench for attn_pass_scheduler: table of per-pass expected descriptors
// plus hand-written sequences for stall, reset, bad-dimension and spurious-input cases.
module tb_attn_pass_scheduler;
  import attn_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              dut_valid;
  logic              dut_ready;
  logic [ADDR_W-1:0] hdr_rd_addr;
  logic              hdr_own;
  logic [DATA_W-1:0] input_hdr;
  logic [DATA_W-1:0] weight_hdr;
  logic              dim_err;
  logic [DATA_W-1:0] in_word;
  logic [DATA_W-1:0] wt_word;

  attn_pass_scheduler_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) cmd_if();

  attn_pass_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dut_valid   (dut_valid),
    .dut_ready   (dut_ready),
    .hdr_rd_addr (hdr_rd_addr),
    .hdr_own     (hdr_own),
    .input_hdr   (input_hdr),
    .weight_hdr  (weight_hdr),
    .cmd         (cmd_if),
    .dim_err     (dim_err)
  );

  // Header SRAM model, one-cycle read latency; garbage unless address 0 is owned.
  always @(posedge clk) begin
    if (hdr_own && hdr_rd_addr == '0) begin
      input_hdr  <= in_word;
      weight_hdr <= wt_word;
    end else begin
      input_hdr  <= 32'hDEAD_BEEF;
      weight_hdr <= 32'hBAD0_BAD0;
    end
  end

  int accepts = 0;
  always @(posedge clk)
    if (cmd_if.cmd_valid && cmd_if.cmd_ready) accepts <= accepts + 1;

  typedef struct {
    logic [15:0] ri, ci, rw, cw;
    logic [1:0]  a_src, b_src;
    logic [15:0] a_base, b_base, dst;
    logic        bt, scr;
    logic [15:0] m, k, n;
  } vec_t;

  vec_t vtab[17];
  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void setv(input int i, input int ri, input int ci, input int rw, input int cw,
                               input int as, input int ab, input int bs, input int bb, input int bt,
                               input int m, input int k, input int n, input int dst, input int scr);
    vtab[i].ri = 16'(ri);  vtab[i].ci = 16'(ci);  vtab[i].rw = 16'(rw);  vtab[i].cw = 16'(cw);
    vtab[i].a_src = 2'(as); vtab[i].a_base = 16'(ab);
    vtab[i].b_src = 2'(bs); vtab[i].b_base = 16'(bb);
    vtab[i].bt = 1'(bt); vtab[i].m = 16'(m); vtab[i].k = 16'(k); vtab[i].n = 16'(n);
    vtab[i].dst = 16'(dst); vtab[i].scr = 1'(scr);
  endfunction

  task automatic check_desc(input int i, input string tag);
    string t;
    t = $sformatf("%s v%0d", tag, i);
    check({t, " a_src"},  32'(cmd_if.cmd_a_src),    32'(vtab[i].a_src));
    check({t, " a_base"}, 32'(cmd_if.cmd_a_base),   32'(vtab[i].a_base));
    check({t, " b_src"},  32'(cmd_if.cmd_b_src),    32'(vtab[i].b_src));
    check({t, " b_base"}, 32'(cmd_if.cmd_b_base),   32'(vtab[i].b_base));
    check({t, " b_trans"},32'(cmd_if.cmd_b_trans),  32'(vtab[i].bt));
    check({t, " m"},      32'(cmd_if.cmd_m),        32'(vtab[i].m));
    check({t, " k"},      32'(cmd_if.cmd_k),        32'(vtab[i].k));
    check({t, " n"},      32'(cmd_if.cmd_n),        32'(vtab[i].n));
    check({t, " dst"},    32'(cmd_if.cmd_dst_base), 32'(vtab[i].dst));
    check({t, " scr"},    32'(cmd_if.cmd_scr_copy), 32'(vtab[i].scr));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " dut_ready"}, 32'(dut_ready), 32'd0);
    check({tag, " cmd_valid"}, 32'(cmd_if.cmd_valid), 32'd0);
    check({tag, " hdr_own"},   32'(hdr_own), 32'd0);
    check({tag, " dim_err"},   32'(dim_err), 32'd0);
    check({tag, " fields"},
          32'({cmd_if.cmd_a_src, cmd_if.cmd_b_src, cmd_if.cmd_b_trans, cmd_if.cmd_scr_copy}), 32'd0);
    check({tag, " bases"},
          32'(cmd_if.cmd_a_base | cmd_if.cmd_b_base | cmd_if.cmd_dst_base), 32'd0);
    check({tag, " dims"}, 32'(cmd_if.cmd_m | cmd_if.cmd_k | cmd_if.cmd_n), 32'd0);
  endtask

  task automatic start_job(input int base);
    @(negedge clk);
    in_word   = {vtab[base].ri, vtab[base].ci};
    wt_word   = {vtab[base].rw, vtab[base].cw};
    dut_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dut_valid = 1'b0;
    check("rd_hdr hdr_own", 32'(hdr_own), 32'd1);
    check("rd_hdr addr", 32'(hdr_rd_addr), 32'd0);
    check("rd_hdr dut_ready", 32'(dut_ready), 32'd0);
  endtask

  task automatic run_job(input int base, input int stall_pass, input bit spur, input int abort_pass);
    int cyc;
    int a0;
    a0 = accepts;
    start_job(base);
    for (int p = 0; p < 5; p++) begin
      cmd_if.cmd_ready = (p != stall_pass);
      cyc = 0;
      while (!cmd_if.cmd_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      if (!cmd_if.cmd_valid) begin
        check($sformatf("cmd_valid timeout v%0d", base + p), 32'd0, 32'd1);
        cmd_if.cmd_ready = 1'b1;
        return;
      end
      check($sformatf("issue latency v%0d", base + p), 32'(cyc), (p == 0) ? 32'd3 : 32'd0);
      check_desc(base + p, "issue");
      if (p == stall_pass) begin
        for (int s = 0; s < 3; s++) begin
          if (spur && s == 1) cmd_if.eng_done = 1'b1;
          @(negedge clk);
          cmd_if.eng_done = 1'b0;
          check($sformatf("stall%0d cmd_valid", s), 32'(cmd_if.cmd_valid), 32'd1);
          check_desc(base + p, $sformatf("stall%0d", s));
        end
        cmd_if.cmd_ready = 1'b1;
      end
      if (spur) cmd_if.eng_done = 1'b1;
      @(negedge clk);
      cmd_if.eng_done = 1'b0;
      check($sformatf("accepted v%0d cmd_valid", base + p), 32'(cmd_if.cmd_valid), 32'd0);
      if (p == abort_pass) begin
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outs("abort");
        reset_n = 1'b1;
        @(negedge clk);
        check("abort release dut_ready", 32'(dut_ready), 32'd1);
        return;
      end
      if (spur) begin
        dut_valid = 1'b1;
        @(negedge clk);
        dut_valid = 1'b0;
        check("wait dut_valid cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("wait dut_valid hdr_own", 32'(hdr_own), 32'd0);
        @(negedge clk);
      end else begin
        repeat (2) @(negedge clk);
      end
      @(negedge clk);
      cmd_if.eng_done = 1'b1;
      @(negedge clk);
      cmd_if.eng_done = 1'b0;
    end
    check("done dut_ready low", 32'(dut_ready), 32'd0);
    @(negedge clk);
    check("done dut_ready high", 32'(dut_ready), 32'd1);
    check("job accepts", 32'(accepts - a0), 32'd5);
    check("job dim_err", 32'(dim_err), 32'd0);
  endtask

  task automatic run_err(input int base);
    start_job(base);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("err c%0d cmd_valid", c), 32'(cmd_if.cmd_valid), 32'd0);
      check($sformatf("err c%0d dut_ready", c), 32'(dut_ready), 32'd0);
    end
    check("err dim_err", 32'(dim_err), 32'd1);
    @(negedge clk);
    check("err dut_ready back", 32'(dut_ready), 32'd1);
    check("err dim_err held", 32'(dim_err), 32'd1);
    check("err cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Job A: 2x3 . 3x2 -> Wd=6, P=4, SS=4
    setv(0,  2,3,3,2,  0,1,   1,1,  0, 2,3,2,  0, 0);
    setv(1,  2,3,3,2,  0,1,   1,7,  0, 2,3,2,  4, 1);
    setv(2,  2,3,3,2,  0,1,   1,13, 0, 2,3,2,  8, 0);
    setv(3,  2,3,3,2,  2,0,   3,0,  1, 2,2,2, 12, 0);
    setv(4,  2,3,3,2,  2,12,  2,8,  0, 2,2,2, 16, 0);
    // Job B: 2x2 . 2x2 -> Wd=4, P=4, SS=4
    setv(5,  2,2,2,2,  0,1,   1,1,  0, 2,2,2,  0, 0);
    setv(6,  2,2,2,2,  0,1,   1,5,  0, 2,2,2,  4, 1);
    setv(7,  2,2,2,2,  0,1,   1,9,  0, 2,2,2,  8, 0);
    setv(8,  2,2,2,2,  2,0,   3,0,  1, 2,2,2, 12, 0);
    setv(9,  2,2,2,2,  2,12,  2,8,  0, 2,2,2, 16, 0);
    // Job C: 4x1 . 1x3 -> Wd=3, P=12, SS=16
    setv(10, 4,1,1,3,  0,1,   1,1,  0, 4,1,3,  0, 0);
    setv(11, 4,1,1,3,  0,1,   1,4,  0, 4,1,3, 12, 1);
    setv(12, 4,1,1,3,  0,1,   1,7,  0, 4,1,3, 24, 0);
    setv(13, 4,1,1,3,  2,0,   3,0,  1, 4,3,4, 36, 0);
    setv(14, 4,1,1,3,  2,36,  2,24, 0, 4,4,3, 52, 0);
    // Rejected headers: Ci != Rw, and a zero dimension
    setv(15, 2,3,4,2,  0,0,0,0,0, 0,0,0, 0, 0);
    setv(16, 0,3,3,2,  0,0,0,0,0, 0,0,0, 0, 0);

    reset_n = 1'b0;
    dut_valid = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    cmd_if.eng_done = 1'b0;
    in_word = '0;
    wt_word = '0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset dut_ready", 32'(dut_ready), 32'd1);

    cmd_if.eng_done = 1'b1;
    @(negedge clk);
    cmd_if.eng_done = 1'b0;
    check("idle eng_done dut_ready", 32'(dut_ready), 32'd1);
    check("idle eng_done cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("idle eng_done hdr_own", 32'(hdr_own), 32'd0);

    run_job(0, -1, 1'b0, -1);
    run_job(0, 2, 1'b1, -1);
    run_err(15);
    run_err(16);
    run_job(0, -1, 1'b0, 3);
    run_job(0, -1, 1'b0, -1);
    run_job(5, -1, 1'b0, -1);
    run_job(10, -1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/attn_pass_scheduler.md
# attn_pass_scheduler

- Sequences the five matrix-multiply passes of one self-attention job (Q, K, V, S = Q·Kᵀ, Z = S·V) on the shared MAC engine.
- Owns the top-level valid/ready handshake and reads the two dimension header words.
- Derives every pass descriptor (operand sources, base addresses, m/k/n, destination) and issues descriptors one at a time, waiting for the engine's completion pulse between passes.
- Sits between the testbench handshake and the MAC datapath; contains no arithmetic on matrix data.

## Interface
Parameters:
- ADDR_W, 16, SRAM address width
- DATA_W, 32, SRAM data width
- DIM_W, 16, matrix dimension width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- dut_valid  in  1  job start request
- dut_ready  out  1  idle/complete indicator
- hdr_rd_addr  out  ADDR_W  header read address, constant 0
- hdr_own  out  1  scheduler owns input/weight SRAM read ports (external mux select)
- input_hdr  in  DATA_W  input SRAM read data; [31:16] rows, [15:0] cols
- weight_hdr  in  DATA_W  weight SRAM read data; same field layout
- cmd_valid  out  1  descriptor valid
- cmd_ready  in  1  engine accepts descriptor
- cmd_a_src, cmd_b_src  out  2  operand source, src_e
- cmd_a_base, cmd_b_base, cmd_dst_base  out  ADDR_W  base addresses
- cmd_b_trans  out  1  read B transposed
- cmd_m, cmd_k, cmd_n  out  DIM_W  result rows, inner dimension, result cols
- cmd_scr_copy  out  1  also write result to scratchpad at address 0
- eng_done  in  1  one-cycle pulse, pass finished
- dim_err  out  1  last job rejected for bad dimensions

## Operation
States: IDLE → RD_HDR → LD_HDR → CALC → ISSUE ⇄ WAIT → DONE → IDLE.
- IDLE: dut_ready=1. dut_valid=1 → RD_HDR. dut_valid while not in IDLE is ignored.
- RD_HDR: hdr_own=1, hdr_rd_addr=0.
- LD_HDR: hdr_own=1. Capture Ri, Ci from input_hdr and Rw, Cw from weight_hdr.
- CALC: register Wd=Rw·Cw, P=Ri·Cw, SS=Ri·Ri; set pass index=0.
  - Ci≠Rw, or any dimension 0 → set dim_err, go to DONE.
  - Otherwise clear dim_err, go to ISSUE.
- ISSUE: cmd_valid=1; descriptor is stable until cmd_valid&&cmd_ready, then WAIT.
- WAIT: eng_done → pass index+1. Index 5 → DONE, else ISSUE. eng_done in any other state is ignored.
- DONE: one cycle, then IDLE.

Pass table (src_e: INPUT=0, WEIGHT=1, RESULT=2, SCRATCH=3):
- 0 Q: A=INPUT@1, B=WEIGHT@1, m=Ri, k=Ci, n=Cw, dst=0.
- 1 K: A=INPUT@1, B=WEIGHT@1+Wd, m=Ri, k=Ci, n=Cw, dst=P, scr_copy=1.
- 2 V: A=INPUT@1, B=WEIGHT@1+2Wd, m=Ri, k=Ci, n=Cw, dst=2P.
- 3 S: A=RESULT@0, B=SCRATCH@0, b_trans=1, m=Ri, k=Cw, n=Ri, dst=3P.
- 4 Z: A=RESULT@3P, B=RESULT@2P, m=Ri, k=Ri, n=Cw, dst=3P+SS.

Arithmetic: dimension products are full 32-bit internally. Addresses are truncated to ADDR_W (mod 2^16); no overflow check.

## Timing
- Reset values: dut_ready=0, cmd_valid=0, hdr_own=0, dim_err=0, all cmd fields 0, state IDLE.
- dut_ready is registered. It rises one cycle after entering IDLE, including the first cycle after reset release, and falls the cycle after dut_valid is sampled in IDLE.
- Header capture: SRAM read latency is 1. Address is presented in RD_HDR; data is sampled at the end of LD_HDR.
- Minimum latency from dut_valid to the first cmd_valid: 4 cycles.
- cmd_ready=1 and eng_done=1 in the same ISSUE cycle: the descriptor is accepted, eng_done is ignored.
- Reset asserted in any state: next cycle all outputs take reset values, an in-flight descriptor is dropped, and the pass index is cleared.
- dim_err holds until the next job's CALC.

## Structure
- Shared package attn_pkg holds:
  - src_e enum;
  - state enum;
  - localparams for pass count (5), header address (0), weight/input data base (1).
- One sub-module, attn_desc_gen: combinational pass-index → descriptor mapping from registered Ri/Ci/Cw/Wd/P/SS. The FSM and registers stay in the top.

## Test plan
- Ri=2, Ci=3, Rw=3, Cw=2, cmd_ready=1, eng_done 4 cycles after each accept → five descriptors:
  - Q/K/V B bases 1, 7, 13;
  - dst 0, 4, 8, 12, 16;
  - S m=2, k=2, n=2, b_trans=1;
  - dut_ready returns.
- cmd_ready held low 3 cycles on pass 2 → cmd_valid and all fields stable for those cycles; exactly one accept.
- Ci=3, Rw=4 → no cmd_valid ever, dim_err=1, dut_ready high 5 cycles after dut_valid.
- Reset pulsed during WAIT of pass 3 → next cycle all outputs at reset values; a fresh job restarts at pass 0 (Q).
- Spurious eng_done in IDLE and ISSUE, and dut_valid during WAIT → no state or pass-index change.
- Two back-to-back jobs with different dims (2×2·2×2, then 4×1·1×3) → second job's descriptors use the new P=12 and SS=16; dim_err stays 0.
